// File: rtl/sd_access_arbiter.sv
// Two-requester round-robin arbiter in front of one sd_card_controller.
// Serialises whole-block transactions, issues the execute pulse, routes
// strobes/data to the owner and reports done/timeout per transaction.
// All state updates on the falling clock edge, matching the controller.
module sd_access_arbiter #(
   parameter int unsigned START_TIMEOUT = 1024,
   parameter int unsigned CNT_W         = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        op0,
   input  logic        op1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [7:0]  wdata0,
   input  logic [7:0]  wdata1,
   output logic        grant0,
   output logic        grant1,
   output logic        byte_stb0,
   output logic        byte_stb1,
   output logic        blk_done0,
   output logic        blk_done1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [7:0]  rdata,
   output logic [9:0]  xfer_count,
   output logic        sd_op_code,
   output logic        sd_execute,
   output logic [31:0] sd_block_address,
   output logic [7:0]  sd_outgoing_byte,
   input  logic [7:0]  sd_incoming_byte,
   input  logic        sd_finished_byte,
   input  logic        sd_finished_block,
   input  logic        sd_busy
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, ACTIVE, RELEASE} state_t;

   // Timeout fires on the edge where the counter would reach START_TIMEOUT,
   // so done/err appear START_TIMEOUT+1 cycles after the execute cycle.
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
   localparam logic [9:0]       XFER_MAX = 10'd1023;

   state_t            state_q, state_d;
   logic              grant0_q, grant0_d, grant1_q, grant1_d;
   logic              winner_q, winner_d;
   logic              rr_q, rr_d;
   logic              op_q, op_d;
   logic [31:0]       addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [9:0]        xfer_q, xfer_d;
   logic              done0_q, done0_d, done1_q, done1_d;
   logic              err0_q, err0_d, err1_q, err1_d;
   logic              win;
   logic              active;

   // Next-state and register-update decode for the transaction sequencer
   always_comb begin
      state_d  = state_q;
      grant0_d = grant0_q;
      grant1_d = grant1_q;
      winner_d = winner_q;
      rr_d     = rr_q;
      op_d     = op_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      xfer_d   = xfer_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      err0_d   = 1'b0;
      err1_d   = 1'b0;
      win      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!sd_busy && (req0 || req1)) begin
               win      = (req0 && req1) ? rr_q : req1;
               winner_d = win;
               grant0_d = ~win;
               grant1_d = win;
               op_d     = win ? op1 : op0;
               addr_d   = win ? addr1 : addr0;
               xfer_d   = '0;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT_START;
         end
         WAIT_START: begin
            if (sd_busy) begin
               state_d = ACTIVE;
            end else if (cnt_q == TO_LAST) begin
               done0_d = ~winner_q;
               done1_d = winner_q;
               err0_d  = ~winner_q;
               err1_d  = winner_q;
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACTIVE: begin
            if (sd_finished_byte && (xfer_q != XFER_MAX)) begin
               xfer_d = xfer_q + 1'b1;
            end
            if (!sd_busy) begin
               done0_d = ~winner_q;
               done1_d = winner_q;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            grant0_d = 1'b0;
            grant1_d = 1'b0;
            rr_d     = ~winner_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Falling-edge state register with asynchronous abort on reset
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         winner_q <= 1'b0;
         rr_q     <= 1'b0;
         op_q     <= 1'b0;
         addr_q   <= '0;
         cnt_q    <= '0;
         xfer_q   <= '0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant0_q <= grant0_d;
         grant1_q <= grant1_d;
         winner_q <= winner_d;
         rr_q     <= rr_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         xfer_q   <= xfer_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
      end
   end

   // Output routing from the registered grant; byte strobes only count in ACTIVE
   always_comb begin
      active           = (state_q == ACTIVE);
      grant0           = grant0_q;
      grant1           = grant1_q;
      done0            = done0_q;
      done1            = done1_q;
      err0             = err0_q;
      err1             = err1_q;
      xfer_count       = xfer_q;
      sd_op_code       = op_q;
      sd_block_address = addr_q;
      sd_execute       = (state_q == ISSUE);
      sd_outgoing_byte = grant1_q ? wdata1 : wdata0;
      rdata            = sd_incoming_byte;
      byte_stb0        = grant0_q & sd_finished_byte & active;
      byte_stb1        = grant1_q & sd_finished_byte & active;
      blk_done0        = grant0_q & sd_finished_block;
      blk_done1        = grant1_q & sd_finished_block;
   end

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Directed bench for sd_access_arbiter. Stimulus changes 1ns after each
// falling edge; checks are made at that point, event counters at rising edges.
module tb_sd_access_arbiter;

   localparam int TO = 20;

   logic        clk, rst, req0, req1, op0, op1;
   logic [31:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        grant0, grant1, byte_stb0, byte_stb1, blk_done0, blk_done1;
   logic        done0, done1, err0, err1;
   logic [7:0]  rdata;
   logic [9:0]  xfer_count;
   logic        sd_op_code, sd_execute;
   logic [31:0] sd_block_address;
   logic [7:0]  sd_outgoing_byte, sd_incoming_byte;
   logic        sd_finished_byte, sd_finished_block, sd_busy;

   int checks = 0;
   int errors = 0;

   int n_stb0 = 0, n_stb1 = 0, n_blk0 = 0, n_blk1 = 0;
   int n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0;
   int n_gap = 0, n_wbad = 0;
   int order_q[$];
   logic pg0 = 1'b0, pg1 = 1'b0;

   sd_access_arbiter #(.START_TIMEOUT(TO), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .grant0(grant0), .grant1(grant1), .byte_stb0(byte_stb0), .byte_stb1(byte_stb1),
      .blk_done0(blk_done0), .blk_done1(blk_done1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .rdata(rdata), .xfer_count(xfer_count),
      .sd_op_code(sd_op_code), .sd_execute(sd_execute),
      .sd_block_address(sd_block_address), .sd_outgoing_byte(sd_outgoing_byte),
      .sd_incoming_byte(sd_incoming_byte), .sd_finished_byte(sd_finished_byte),
      .sd_finished_block(sd_finished_block), .sd_busy(sd_busy)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // Event counters and grant-order log, sampled mid-cycle
   always @(posedge clk) begin
      n_stb0  += int'(byte_stb0);
      n_stb1  += int'(byte_stb1);
      n_blk0  += int'(blk_done0);
      n_blk1  += int'(blk_done1);
      n_done0 += int'(done0);
      n_done1 += int'(done1);
      n_err0  += int'(err0);
      n_err1  += int'(err1);
      if (grant0 && !pg0) begin
         order_q.push_back(0);
         if (pg1) n_gap++;
      end
      if (grant1 && !pg1) begin
         order_q.push_back(1);
         if (pg0) n_gap++;
      end
      if (grant1 && sd_outgoing_byte !== wdata1) n_wbad++;
      if (grant0 && sd_outgoing_byte !== wdata0) n_wbad++;
      pg0 = grant0;
      pg1 = grant1;
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_exec(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16 && !ok; i++) begin
         cyc();
         if (sd_execute === 1'b1) ok = 1'b1;
      end
   endtask

   // Controller model: busy after 'delay' cycles, nbytes strobes, one block
   // strobe, then busy low. Returns with busy just dropped.
   task automatic serve(input int delay, input int nbytes, input bit stray);
      if (stray) sd_finished_byte = 1'b1;
      for (int i = 0; i < delay; i++) begin
         cyc();
         sd_finished_byte = 1'b0;
      end
      sd_busy = 1'b1;
      cyc();
      for (int i = 0; i < nbytes; i++) begin
         sd_finished_byte = 1'b1;
         sd_incoming_byte = 8'(i);
         cyc();
         sd_finished_byte = 1'b0;
         cyc();
      end
      sd_finished_block = 1'b1;
      cyc();
      sd_finished_block = 1'b0;
      sd_busy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bit bad;
      cyc();
      cyc();
      checks++;
      if ({grant0, grant1, sd_execute, done0, done1, err0, err1, sd_op_code} !== 8'h00) begin
         errors++; $display("FAIL reset_ctrl: got %b want 00000000", {grant0, grant1, sd_execute, done0, done1, err0, err1, sd_op_code});
      end
      checks++;
      if (sd_block_address !== 32'h0 || xfer_count !== 10'd0) begin
         errors++; $display("FAIL reset_regs: addr %h xfer %0d want 0 0", sd_block_address, xfer_count);
      end
      rst = 1'b0;
      bad = 1'b0;
      repeat (50) begin
         cyc();
         if (grant0 || grant1 || sd_execute) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++; $display("FAIL busy_hold: grant/execute seen while busy, got %b want 0", bad);
      end
      sd_busy = 1'b0;
      cyc();
      checks++;
      if (grant0 !== 1'b1 || sd_execute !== 1'b1 || sd_block_address !== 32'hDEADBEEF) begin
         errors++; $display("FAIL first_grant: grant0 %b exec %b addr %h want 1 1 deadbeef", grant0, sd_execute, sd_block_address);
      end
      cyc();
      checks++;
      if (sd_execute !== 1'b0 || grant0 !== 1'b1) begin
         errors++; $display("FAIL exec_width: exec %b grant0 %b want 0 1", sd_execute, grant0);
      end
      serve(1, 2, 1'b0);
      cyc();
      checks++;
      if (done0 !== 1'b1 || err0 !== 1'b0) begin
         errors++; $display("FAIL reset_txn_done: done0 %b err0 %b want 1 0", done0, err0);
      end
      req0 = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic test_read_block();
      int s0, s1, b0, e0;
      bit ok;
      s0 = n_stb0; s1 = n_stb1; b0 = n_blk0; e0 = n_err0;
      op0 = 1'b0; addr0 = 32'h0; req0 = 1'b1;
      wait_exec(ok);
      checks++;
      if (ok !== 1'b1 || grant0 !== 1'b1 || sd_block_address !== 32'h0 || sd_op_code !== 1'b0) begin
         errors++; $display("FAIL read_issue: seen %b grant0 %b addr %h op %b want 1 1 0 0", ok, grant0, sd_block_address, sd_op_code);
      end
      serve(3, 512, 1'b1);
      sd_incoming_byte = 8'h5A;
      cyc();
      checks++;
      if (done0 !== 1'b1 || err0 !== 1'b0 || done1 !== 1'b0) begin
         errors++; $display("FAIL read_done: done0 %b err0 %b done1 %b want 1 0 0", done0, err0, done1);
      end
      checks++;
      if (xfer_count !== 10'd512) begin
         errors++; $display("FAIL read_xfer: got %0d want 512", xfer_count);
      end
      checks++;
      if (rdata !== 8'h5A) begin
         errors++; $display("FAIL rdata: got %h want 5a", rdata);
      end
      req0 = 1'b0;
      cyc();
      checks++;
      if (n_stb0 - s0 != 512 || n_stb1 - s1 != 0 || n_blk0 - b0 != 1 || n_err0 - e0 != 0) begin
         errors++; $display("FAIL read_strobes: stb0 %0d stb1 %0d blk0 %0d err0 %0d want 512 0 1 0", n_stb0 - s0, n_stb1 - s1, n_blk0 - b0, n_err0 - e0);
      end
      checks++;
      if (done0 !== 1'b0 || xfer_count !== 10'd512) begin
         errors++; $display("FAIL read_after: done0 %b xfer %0d want 0 512", done0, xfer_count);
      end
      cyc();
   endtask

   task automatic test_round_robin();
      int start, g0;
      bit ok;
      do_reset();
      start = order_q.size();
      g0 = n_gap;
      addr0 = 32'd100; addr1 = 32'd200; op0 = 1'b0; op1 = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      for (int t = 0; t < 4; t++) begin
         wait_exec(ok);
         checks++;
         if (ok !== 1'b1 || grant0 !== ((t % 2) == 0) || grant1 !== ((t % 2) == 1)) begin
            errors++; $display("FAIL rr_grant%0d: seen %b g0 %b g1 %b want owner %0d", t, ok, grant0, grant1, t % 2);
         end
         serve(1, 2, 1'b0);
         cyc();
         if (t == 3) begin
            req0 = 1'b0; req1 = 1'b0;
         end
      end
      cyc();
      cyc();
      checks++;
      if (order_q.size() - start != 4 || order_q[start] != 0 || order_q[start+1] != 1 ||
          order_q[start+2] != 0 || order_q[start+3] != 1) begin
         errors++; $display("FAIL rr_order: %0d grants logged, want order 0 1 0 1", order_q.size() - start);
      end
      checks++;
      if (n_gap - g0 != 0) begin
         errors++; $display("FAIL rr_gap: got %0d back-to-back grants want 0", n_gap - g0);
      end
   endtask

   task automatic test_write_routing();
      int s0, s1, wb;
      bit ok;
      s0 = n_stb0; s1 = n_stb1; wb = n_wbad;
      wdata0 = 8'h3C; wdata1 = 8'hA5; op1 = 1'b1; addr1 = 32'h0000_55AA; req1 = 1'b1;
      wait_exec(ok);
      checks++;
      if (ok !== 1'b1 || grant1 !== 1'b1 || grant0 !== 1'b0 || sd_op_code !== 1'b1 || sd_block_address !== 32'h0000_55AA) begin
         errors++; $display("FAIL wr_issue: seen %b g1 %b g0 %b op %b addr %h want 1 1 0 1 000055aa", ok, grant1, grant0, sd_op_code, sd_block_address);
      end
      checks++;
      if (sd_outgoing_byte !== 8'hA5) begin
         errors++; $display("FAIL wr_data: got %h want a5", sd_outgoing_byte);
      end
      op1 = 1'b0; addr1 = 32'hFFFF_FFFF;
      serve(2, 3, 1'b0);
      checks++;
      if (sd_op_code !== 1'b1 || sd_block_address !== 32'h0000_55AA) begin
         errors++; $display("FAIL wr_latched: op %b addr %h want 1 000055aa", sd_op_code, sd_block_address);
      end
      cyc();
      checks++;
      if (done1 !== 1'b1 || err1 !== 1'b0 || done0 !== 1'b0) begin
         errors++; $display("FAIL wr_done: done1 %b err1 %b done0 %b want 1 0 0", done1, err1, done0);
      end
      req1 = 1'b0;
      cyc();
      checks++;
      if (n_stb1 - s1 != 3 || n_stb0 - s0 != 0 || n_wbad - wb != 0) begin
         errors++; $display("FAIL wr_routing: stb1 %0d stb0 %0d baddata %0d want 3 0 0", n_stb1 - s1, n_stb0 - s0, n_wbad - wb);
      end
      cyc();
   endtask

   task automatic test_timeout();
      bit ok, early;
      addr1 = 32'h0000_0777; addr0 = 32'h0000_0888; req1 = 1'b1;
      wait_exec(ok);
      checks++;
      if (ok !== 1'b1 || grant1 !== 1'b1) begin
         errors++; $display("FAIL to_issue: seen %b grant1 %b want 1 1", ok, grant1);
      end
      req0 = 1'b1;
      early = 1'b0;
      repeat (TO) begin
         cyc();
         if (done1 || err1 || done0) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin
         errors++; $display("FAIL to_early: got %b want 0", early);
      end
      cyc();
      checks++;
      if (done1 !== 1'b1 || err1 !== 1'b1 || grant1 !== 1'b1 || grant0 !== 1'b0) begin
         errors++; $display("FAIL to_pulse: done1 %b err1 %b g1 %b g0 %b want 1 1 1 0", done1, err1, grant1, grant0);
      end
      req1 = 1'b0;
      cyc();
      checks++;
      if (grant1 !== 1'b0 || done1 !== 1'b0 || err1 !== 1'b0) begin
         errors++; $display("FAIL to_release: g1 %b done1 %b err1 %b want 0 0 0", grant1, done1, err1);
      end
      cyc();
      checks++;
      if (grant0 !== 1'b1 || sd_execute !== 1'b1 || sd_block_address !== 32'h0000_0888) begin
         errors++; $display("FAIL to_queued: g0 %b exec %b addr %h want 1 1 00000888", grant0, sd_execute, sd_block_address);
      end
      serve(1, 1, 1'b0);
      cyc();
      checks++;
      if (done0 !== 1'b1 || err0 !== 1'b0) begin
         errors++; $display("FAIL to_queued_done: done0 %b err0 %b want 1 0", done0, err0);
      end
      req0 = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic test_saturate();
      bit ok;
      req0 = 1'b1;
      wait_exec(ok);
      serve(1, 1030, 1'b0);
      cyc();
      checks++;
      if (ok !== 1'b1 || done0 !== 1'b1 || xfer_count !== 10'd1023) begin
         errors++; $display("FAIL saturate: seen %b done0 %b xfer %0d want 1 1 1023", ok, done0, xfer_count);
      end
      req0 = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic test_reset_active();
      int d0, d1;
      bit ok;
      req1 = 1'b1;
      wait_exec(ok);
      cyc();
      sd_busy = 1'b1;
      cyc();
      cyc();
      sd_finished_byte = 1'b1;
      cyc();
      sd_finished_byte = 1'b0;
      cyc();
      checks++;
      if (ok !== 1'b1 || grant1 !== 1'b1 || xfer_count !== 10'd1) begin
         errors++; $display("FAIL ra_active: seen %b g1 %b xfer %0d want 1 1 1", ok, grant1, xfer_count);
      end
      d0 = n_done0; d1 = n_done1;
      rst = 1'b1;
      sd_finished_byte = 1'b1;
      #1;
      checks++;
      if ({grant0, grant1, sd_execute, byte_stb1, done1, err1, sd_op_code} !== 7'h00 ||
          sd_block_address !== 32'h0 || xfer_count !== 10'd0) begin
         errors++; $display("FAIL ra_async: ctrl %b addr %h xfer %0d want 0000000 0 0", {grant0, grant1, sd_execute, byte_stb1, done1, err1, sd_op_code}, sd_block_address, xfer_count);
      end
      sd_finished_byte = 1'b0;
      sd_busy = 1'b0;
      req0 = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      checks++;
      if (grant0 !== 1'b1 || grant1 !== 1'b0 || sd_execute !== 1'b1) begin
         errors++; $display("FAIL ra_tie: g0 %b g1 %b exec %b want 1 0 1", grant0, grant1, sd_execute);
      end
      checks++;
      if (n_done0 != d0 || n_done1 != d1) begin
         errors++; $display("FAIL ra_nodone: done pulses %0d/%0d want 0/0", n_done0 - d0, n_done1 - d1);
      end
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      cyc();
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b1; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
      addr0 = 32'hDEADBEEF; addr1 = 32'h0; wdata0 = 8'h00; wdata1 = 8'h00;
      sd_incoming_byte = 8'h00; sd_finished_byte = 1'b0; sd_finished_block = 1'b0;
      sd_busy = 1'b1;
      test_reset();
      test_read_block();
      test_round_robin();
      test_write_routing();
      test_timeout();
      test_saturate();
      test_reset_active();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
